// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: hold all channels, release them one by one, then supervise the run.
// Optional run watchdog is enabled by defining RESET_SEQUENCER_WATCHDOG_EN.
module reset_sequencer #(
   parameter int CH         = 2,
   parameter int HOLD       = 4,
   parameter int STAGGER    = 2,
   parameter int RUN_CYCLES = 40
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          restart,
   input  logic          halt,
   output logic [CH-1:0] nReset_out,
   output logic          running,
   output logic          done,
   output logic          timeout,
   output logic [15:0]   cycle_cnt
);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t        state_reg;
   logic [7:0]    hold_cnt_reg;
   logic [15:0]   rel_cnt_reg;
   logic [CH-1:0] nrst_reg;
   logic [CH-1:0] rel_mask;
   logic          running_reg;
   logic          done_reg;
   logic          timeout_reg;
   logic [15:0]   cycle_cnt_reg;
   logic [15:0]   cycle_cnt_next;

   assign cycle_cnt_next = (cycle_cnt_reg == 16'hFFFF) ? cycle_cnt_reg : cycle_cnt_reg + 16'd1;

   // Channel gi is due once the release counter reaches gi*STAGGER; STAGGER=0 frees all at once.
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_rel
         localparam int REL_AT = gi * STAGGER;
         assign rel_mask[gi] = (rel_cnt_reg >= 16'(REL_AT));
      end
   endgenerate

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= ST_HOLD;
         hold_cnt_reg  <= 8'd0;
         rel_cnt_reg   <= 16'd0;
         nrst_reg      <= '0;
         running_reg   <= 1'b0;
         done_reg      <= 1'b0;
         timeout_reg   <= 1'b0;
         cycle_cnt_reg <= 16'd0;
      end else if (restart) begin
         state_reg     <= ST_HOLD;
         hold_cnt_reg  <= 8'd0;
         rel_cnt_reg   <= 16'd0;
         nrst_reg      <= '0;
         running_reg   <= 1'b0;
         done_reg      <= 1'b0;
         timeout_reg   <= 1'b0;
         cycle_cnt_reg <= 16'd0;
      end else begin
         case (state_reg)
            ST_HOLD: begin
               if (hold_cnt_reg == 8'(HOLD - 1)) begin
                  state_reg    <= ST_RELEASE;
                  hold_cnt_reg <= 8'd0;
                  rel_cnt_reg  <= 16'd0;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg + 8'd1;
               end
            end
            ST_RELEASE: begin
               if (&nrst_reg) begin
                  state_reg     <= ST_RUN;
                  running_reg   <= 1'b1;
                  cycle_cnt_reg <= 16'd0;
               end else begin
                  nrst_reg    <= nrst_reg | rel_mask;
                  rel_cnt_reg <= rel_cnt_reg + 16'd1;
               end
            end
            ST_RUN: begin
               // halt outranks the watchdog; cycle_cnt freezes on the exit edge
               if (halt) begin
                  state_reg   <= ST_DONE;
                  running_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  timeout_reg <= 1'b0;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
               end else if (cycle_cnt_reg == 16'(RUN_CYCLES - 1)) begin
                  state_reg   <= ST_DONE;
                  running_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  timeout_reg <= 1'b1;
`endif
               end else begin
                  cycle_cnt_reg <= cycle_cnt_next;
               end
            end
            ST_DONE: begin
               state_reg <= ST_DONE;
            end
            default: begin
               state_reg <= ST_HOLD;
            end
         endcase
      end
   end

   assign nReset_out = nrst_reg;
   assign running    = running_reg;
   assign done       = done_reg;
   assign timeout    = timeout_reg;
   assign cycle_cnt  = cycle_cnt_reg;

endmodule
